// File: rtl/leg_solver_pkg.sv
// Shared types and constants for the leg solver: FSM encoding, root-iteration
// parameters and the small arithmetic helpers used by the datapath.
package leg_solver_pkg;

    typedef enum logic [2:0] {
        ST_SAMPLE = 3'd0,
        ST_SQUARE = 3'd1,
        ST_DIFF   = 3'd2,
        ST_ROOT   = 3'd3,
        ST_OUT    = 3'd4
    } state_e;

    localparam logic [3:0]  ROOT_ITERS = 4'd8;
    localparam logic [15:0] BIT_INIT   = 16'h4000;
    localparam logic [7:0]  UIO_OE_VAL = 8'h80;

    // Full-width 8x8 square, never truncated (255*255 = 65025).
    function automatic logic [15:0] sq8(input logic [7:0] v);
        return {8'd0, v} * {8'd0, v};
    endfunction

    // r^2 - x^2 clamped to zero when the leg is longer than the hypotenuse.
    function automatic logic [15:0] leg_diff(input logic [15:0] r2, input logic [15:0] x2,
                                             input logic x_gt_r);
        return x_gt_r ? 16'd0 : (r2 - x2);
    endfunction

endpackage

// File: rtl/isqrt16_iter.sv
// Bit-serial 16-bit integer square root: one digit per enabled cycle, exactly
// ROOT_ITERS iterations after a start pulse, frozen whenever ena is low.
module isqrt16_iter
    import leg_solver_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic [15:0] num_in,
    output logic [7:0]  root_out,
    output logic        busy
);

    logic [15:0] num_r;
    logic [15:0] res_r;
    logic [15:0] bit_r;
    logic [3:0]  cnt_r;
    logic        run_r;
    logic [15:0] trial_s;

    assign trial_s  = res_r + bit_r;
    assign root_out = res_r[7:0];
    // busy drops during the final iteration so the caller can leave ROOT on time.
    assign busy     = run_r && (cnt_r != (ROOT_ITERS - 4'd1));

    // Load operands on start, then apply one restoring-root step per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_r <= 16'd0;
            res_r <= 16'd0;
            bit_r <= 16'd0;
            cnt_r <= 4'd0;
            run_r <= 1'b0;
        end else if (ena) begin
            if (start) begin
                num_r <= num_in;
                res_r <= 16'd0;
                bit_r <= BIT_INIT;
                cnt_r <= 4'd0;
                run_r <= 1'b1;
            end else if (run_r) begin
                if (num_r >= trial_s) begin
                    num_r <= num_r - trial_s;
                    res_r <= (res_r >> 1) + bit_r;
                end else begin
                    res_r <= res_r >> 1;
                end
                bit_r <= bit_r >> 2;
                cnt_r <= cnt_r + 4'd1;
                if (cnt_r == (ROOT_ITERS - 4'd1)) begin
                    run_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tt_um_leg_solver.sv
// Right-triangle leg solver: y = floor(sqrt(r^2 - x^2)), one result every
// 12 enabled cycles through SAMPLE/SQUARE/DIFF/ROOT/OUT.
module tt_um_leg_solver
    import leg_solver_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [7:0]  r_r;
    logic [6:0]  x_r;
    logic [15:0] r2_r;
    logic [15:0] x2_r;
    logic [7:0]  y_r;
    logic        done_r;
    logic        start_s;
    logic        busy_s;
    logic [15:0] num_s;
    logic [7:0]  root_s;
    logic        unused_s;

    assign unused_s = uio_in[7];
    assign num_s    = leg_diff(r2_r, x2_r, ({1'b0, x_r} > r_r));
    assign start_s  = ena && (state_r == ST_DIFF);

    assign uo_out   = y_r;
    assign uio_out  = {done_r, 7'd0};
    assign uio_oe   = UIO_OE_VAL;

    isqrt16_iter u_root (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start_s),
        .num_in   (num_s),
        .root_out (root_s),
        .busy     (busy_s)
    );

    // Free-running state sequence; ROOT is held until the root unit finishes.
    always_comb begin
        state_nxt_s = ST_SAMPLE;
        case (state_r)
            ST_SAMPLE: state_nxt_s = ST_SQUARE;
            ST_SQUARE: state_nxt_s = ST_DIFF;
            ST_DIFF:   state_nxt_s = ST_ROOT;
            ST_ROOT: begin
                if (busy_s) begin
                    state_nxt_s = ST_ROOT;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            ST_OUT:    state_nxt_s = ST_SAMPLE;
            default:   state_nxt_s = ST_SAMPLE;
        endcase
    end

    // Operand capture, squaring, result register and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SAMPLE;
            r_r     <= 8'd0;
            x_r     <= 7'd0;
            r2_r    <= 16'd0;
            x2_r    <= 16'd0;
            y_r     <= 8'd0;
            done_r  <= 1'b0;
        end else if (ena) begin
            state_r <= state_nxt_s;
            done_r  <= (state_r == ST_OUT);
            if (state_r == ST_SAMPLE) begin
                r_r <= ui_in;
                x_r <= uio_in[6:0];
            end
            if (state_r == ST_SQUARE) begin
                r2_r <= sq8(r_r);
                x2_r <= sq8({1'b0, x_r});
            end
            if (state_r == ST_OUT) begin
                y_r <= root_s;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tt_um_leg_solver.sv
// Directed bench for tt_um_leg_solver: hand-computed leg lengths, latency,
// input isolation, ena hold and mid-computation reset.
module tb_tt_um_leg_solver;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks_r;
    int errors_r;

    tt_um_leg_solver dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count edges until done; also count cycles where uo_out moved before done.
    task automatic wait_done(output int n, output int early);
        logic [7:0] start_y;
        start_y = uo_out;
        n       = 0;
        early   = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!uio_out[7] && (uo_out != start_y)) early++;
        end while (!uio_out[7] && n < 40);
    endtask

    task automatic run_vec(input string tag, input logic [7:0] r, input logic [7:0] xin,
                           input logic [7:0] exp);
        int n;
        int early;
        ui_in  = r;
        uio_in = xin;
        wait_done(n, early);
        check({tag, "_lat"}, n, 12);
        check({tag, "_y"}, uo_out, exp);
        check({tag, "_early"}, early, 0);
    endtask

    initial begin
        int n;
        int early;
        int bad;
        checks_r = 0;
        errors_r = 0;
        rst_n    = 1'b0;
        ena      = 1'b0;
        ui_in    = 8'd0;
        uio_in   = 8'd0;
        #1;
        check("rst_y", uo_out, 0);
        check("rst_uio", uio_out, 0);
        check("rst_oe", uio_oe, 8'h80);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        run_vec("r5x3", 8'd5, 8'd3, 8'd4);
        run_vec("r255x0", 8'd255, 8'd0, 8'd255);
        run_vec("r13x12", 8'd13, 8'h8C, 8'd5);
        run_vec("r200x127", 8'd200, 8'd127, 8'd154);
        run_vec("x_gt_r", 8'd10, 8'd11, 8'd0);
        run_vec("x_eq_r", 8'd9, 8'd9, 8'd0);

        // Inputs change while ROOT runs: in-flight result must be unaffected.
        ui_in  = 8'd5;
        uio_in = 8'd3;
        repeat (5) @(posedge clk);
        #1;
        ui_in  = 8'd13;
        uio_in = 8'd12;
        wait_done(n, early);
        check("iso_lat", n, 7);
        check("iso_y", uo_out, 4);
        run_vec("iso_next", 8'd13, 8'd12, 8'd5);

        // Freeze for 20 cycles in ROOT, then resume.
        ui_in  = 8'd200;
        uio_in = 8'd127;
        repeat (6) @(posedge clk);
        #1;
        ena    = 1'b0;
        ui_in  = 8'd1;
        uio_in = 8'd0;
        bad    = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (uo_out != 8'd5 || uio_out != 8'd0) bad++;
        end
        check("hold_frozen", bad, 0);
        ena = 1'b1;
        wait_done(n, early);
        check("hold_lat", n, 6);
        check("hold_y", uo_out, 154);

        // Reset while in DIFF.
        ui_in  = 8'd255;
        uio_in = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_y", uo_out, 0);
        check("mid_rst_uio", uio_out, 0);
        check("mid_rst_oe", uio_oe, 8'h80);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_rst", 8'd13, 8'd12, 8'd5);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule
